// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcode constants,
// the one-hot class vector, the opcode decoder and the immediate extender.
package id_pkg;

   localparam int unsigned OP_W  = 7;
   localparam int unsigned IMM_W = 16;
   localparam int unsigned EXT_W = 64;

   localparam logic [OP_W-1:0] OP_CMP = 7'b0000100;
   localparam logic [OP_W-1:0] OP_LD  = 7'b0011000;
   localparam logic [OP_W-1:0] OP_ST  = 7'b0011001;

   typedef struct packed {
      logic inte;
      logic lgc;
      logic shift;
      logic set;
      logic ld;
      logic st;
      logic br;
      logic und;
   } cls_t;

   typedef struct packed {
      cls_t cls;
      logic wr_rd;
   } dec_t;

   function automatic dec_t decode(input logic [OP_W-1:0] op);
      dec_t d;
      d = '0;
      if (op[6:3] == 4'b0000)                         d.cls.inte  = 1'b1;
      else if (op[6:3] == 4'b0001 && op[2:0] <= 3'd5) d.cls.shift = 1'b1;
      else if (op[6:2] == 5'b00100)                   d.cls.lgc   = 1'b1;
      else if (op[6:1] == 6'b001011)                  d.cls.set   = 1'b1;
      else if (op == OP_LD)                           d.cls.ld    = 1'b1;
      else if (op == OP_ST)                           d.cls.st    = 1'b1;
      else if (op[6:2] == 5'b00111)                   d.cls.br    = 1'b1;
      else                                            d.cls.und   = 1'b1;
      d.wr_rd = (d.cls.inte && op != OP_CMP) || d.cls.shift || d.cls.lgc ||
                d.cls.set || d.cls.ld;
      return d;
   endfunction

   // Shift immediates are unsigned, every other class sign-extends.
   function automatic logic [EXT_W-1:0] extend(input logic [IMM_W-1:0] imm, input logic zext);
      logic [EXT_W-1:0] r;
      if (zext) r = {{(EXT_W-IMM_W){1'b0}}, imm};
      else      r = {{(EXT_W-IMM_W){imm[IMM_W-1]}}, imm};
      return r;
   endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Register file with per-register reservation bits, write-back bypass,
// two read ports, one write port and reservation set/clear ports.
module gpr_scoreboard #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 16,
   parameter int unsigned RA_W = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RA_W-1:0] ra0,
   input  logic [RA_W-1:0] ra1,
   output logic [XLEN-1:0] rdata0_c,
   output logic [XLEN-1:0] rdata1_c,
   output logic            busy0_c,
   output logic            busy1_c,
   input  logic            wb,
   input  logic [RA_W-1:0] wb_r,
   input  logic [XLEN-1:0] wb_data,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_r,
   input  logic            clr_en,
   input  logic [RA_W-1:0] clr_r
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] rsv;
   logic [NREG-1:0] rsv_nxt;

   function automatic logic [XLEN-1:0] rd_val(input logic [RA_W-1:0] a);
      logic [XLEN-1:0] v;
      if (a == '0)                  v = '0;
      else if (wb && wb_r == a)     v = wb_data;
      else                          v = regs[a];
      return v;
   endfunction

   // A reservation being released by this cycle's write-back is already free.
   function automatic logic is_busy(input logic [RA_W-1:0] a);
      return rsv[a] && !(wb && wb_r == a);
   endfunction

   assign rdata0_c = rd_val(ra0);
   assign rdata1_c = rd_val(ra1);
   assign busy0_c  = is_busy(ra0);
   assign busy1_c  = is_busy(ra1);

   // Issue set takes priority over any clear of the same register.
   always_comb begin
      rsv_nxt = rsv;
      if (wb)                      rsv_nxt[wb_r]  = 1'b0;
      if (clr_en)                  rsv_nxt[clr_r] = 1'b0;
      if (set_en && set_r != '0)   rsv_nxt[set_r] = 1'b1;
      rsv_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
         rsv <= '0;
      end else begin
         if (wb && wb_r != '0) regs[wb_r] <= wb_data;
         rsv <= rsv_nxt;
      end
   end

endmodule

// File: rtl/id_stage_p.sv
// Instruction-decode stage: decode, operand read with hazard stall,
// and a single valid/ready output slot with flush.
module id_stage_p
   import id_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 16,
   parameter int unsigned RA_W = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   input  logic            flush_i,
   input  logic            wb_i,
   input  logic [RA_W-1:0] wb_r_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] opr0_value_o,
   output logic [XLEN-1:0] opr1_value_o,
   output logic [RA_W-1:0] rd_addr_o,
   output logic            wr_rd_o,
   output logic            ctrl_inte_o,
   output logic            ctrl_logic_o,
   output logic            ctrl_shift_o,
   output logic            ctrl_set_o,
   output logic            ctrl_ld_o,
   output logic            ctrl_st_o,
   output logic            ctrl_br_o,
   output logic            ctrl_und_o,
   output logic            stall_o
);

   dec_t            dec;
   logic            imm_sel;
   logic [RA_W-1:0] rd_a;
   logic [RA_W-1:0] rs_a;
   logic [XLEN-1:0] rd_val_c;
   logic [XLEN-1:0] rs_val_c;
   logic            rd_busy_c;
   logic            rs_busy_c;
   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] opr0_nxt;
   logic [XLEN-1:0] opr1_nxt;
   cls_t            slot_cls;

   assign dec     = decode(inst_i[31:25]);
   assign imm_sel = inst_i[24];
   assign rd_a    = inst_i[20 +: RA_W];
   assign rs_a    = inst_i[16 +: RA_W];

   gpr_scoreboard #(.XLEN(XLEN), .NREG(NREG), .RA_W(RA_W)) u_gpr (
      .clk      (clk),
      .rst      (rst),
      .ra0      (rd_a),
      .ra1      (rs_a),
      .rdata0_c (rd_val_c),
      .rdata1_c (rs_val_c),
      .busy0_c  (rd_busy_c),
      .busy1_c  (rs_busy_c),
      .wb       (wb_i),
      .wb_r     (wb_r_i),
      .wb_data  (wb_data_i),
      .set_en   (accept && dec.wr_rd),
      .set_r    (rd_a),
      .clr_en   (flush_i && out_valid_o && wr_rd_o),
      .clr_r    (rd_addr_o)
   );

   // rs only matters when it is actually read, i.e. no immediate.
   assign hazard     = rd_busy_c || (rs_busy_c && !imm_sel);
   assign in_ready_o = !hazard && !flush_i && (!out_valid_o || out_ready_i);
   assign stall_o    = in_valid_i && hazard;
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      opr0_nxt = rd_val_c;
      opr1_nxt = imm_sel ? XLEN'(extend(inst_i[15:0], dec.cls.shift)) : rs_val_c;
      if (dec.cls.und) begin
         opr0_nxt = '0;
         opr1_nxt = '0;
      end
   end

   // Output slot: load on accept, drain on handshake or flush, else hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o  <= 1'b0;
         opr0_value_o <= '0;
         opr1_value_o <= '0;
         rd_addr_o    <= '0;
         wr_rd_o      <= 1'b0;
         slot_cls     <= '0;
      end else if (accept) begin
         out_valid_o  <= 1'b1;
         opr0_value_o <= opr0_nxt;
         opr1_value_o <= opr1_nxt;
         rd_addr_o    <= rd_a;
         wr_rd_o      <= dec.wr_rd;
         slot_cls     <= dec.cls;
      end else if (flush_i || out_ready_i) begin
         out_valid_o  <= 1'b0;
      end
   end

   assign ctrl_inte_o  = slot_cls.inte;
   assign ctrl_logic_o = slot_cls.lgc;
   assign ctrl_shift_o = slot_cls.shift;
   assign ctrl_set_o   = slot_cls.set;
   assign ctrl_ld_o    = slot_cls.ld;
   assign ctrl_st_o    = slot_cls.st;
   assign ctrl_br_o    = slot_cls.br;
   assign ctrl_und_o   = slot_cls.und;

endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: directed scenarios plus random traffic, checked against
// an array-based reference model through an expected-slot queue.
module tb_id_stage_p;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 16;
   localparam int unsigned RA_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     inst_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic            out_valid_o;
   logic            out_ready_i;
   logic            flush_i;
   logic            wb_i;
   logic [RA_W-1:0] wb_r_i;
   logic [XLEN-1:0] wb_data_i;
   logic [XLEN-1:0] opr0_value_o;
   logic [XLEN-1:0] opr1_value_o;
   logic [RA_W-1:0] rd_addr_o;
   logic            wr_rd_o;
   logic            ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_set_o;
   logic            ctrl_ld_o, ctrl_st_o, ctrl_br_o, ctrl_und_o;
   logic            stall_o;

   id_stage_p #(.XLEN(XLEN), .NREG(NREG), .RA_W(RA_W)) dut (
      .clk(clk), .rst(rst), .inst_i(inst_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .flush_i(flush_i), .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
      .opr0_value_o(opr0_value_o), .opr1_value_o(opr1_value_o), .rd_addr_o(rd_addr_o),
      .wr_rd_o(wr_rd_o), .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o),
      .ctrl_shift_o(ctrl_shift_o), .ctrl_set_o(ctrl_set_o), .ctrl_ld_o(ctrl_ld_o),
      .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o), .ctrl_und_o(ctrl_und_o),
      .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] o0;
      logic [31:0] o1;
      logic [3:0]  rd;
      logic        wr;
      logic [7:0]  cls;
   } exp_t;

   exp_t        q[$];
   exp_t        pend;
   bit          pend_v;
   int          n_tests;
   int          n_fail;
   bit          mon_en;
   logic [31:0] m_reg [16];
   bit          m_rsv [16];
   bit          m_sv;
   bit          m_swr;
   int          m_srd;
   int          ops [12] = '{0, 4, 7, 8, 13, 14, 17, 22, 24, 25, 29, 127};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input bit imm, input int rd,
                                      input int rs, input int imm16);
      logic [31:0] r;
      r = {7'(op), imm, 4'(rd), 4'(rs), 16'(imm16)};
      return r;
   endfunction

   // Class vector order: inte, logic, shift, set, ld, st, br, und.
   function automatic logic [7:0] m_cls(input int op);
      if (op < 8)                  return 8'h80;
      if (op >= 8 && op <= 13)     return 8'h20;
      if (op >= 16 && op <= 19)    return 8'h40;
      if (op == 22 || op == 23)    return 8'h10;
      if (op == 24)                return 8'h08;
      if (op == 25)                return 8'h04;
      if (op >= 28 && op <= 31)    return 8'h02;
      return 8'h01;
   endfunction

   function automatic bit m_wr(input int op);
      logic [7:0] c;
      c = m_cls(op);
      return (op < 8 && op != 4) || c == 8'h20 || c == 8'h40 || c == 8'h10 || c == 8'h08;
   endfunction

   function automatic logic [31:0] m_read(input int a);
      if (a == 0) return 32'h0;
      if (wb_i && int'(wb_r_i) == a) return wb_data_i;
      return m_reg[a];
   endfunction

   function automatic bit m_busy(input int a);
      return m_rsv[a] && !(wb_i && int'(wb_r_i) == a);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_reg[i] = 32'h0;
         m_rsv[i] = 1'b0;
      end
      m_sv = 1'b0;
      m_swr = 1'b0;
      m_srd = 0;
      q.delete();
      pend_v = 1'b0;
   endtask

   task automatic model_step();
      int          op, rd, rs, i16;
      bit          imm, hz, rdy, acc, wr;
      logic [31:0] ext;
      op  = int'(inst_i[31:25]);
      imm = inst_i[24];
      rd  = int'(inst_i[23:20]);
      rs  = int'(inst_i[19:16]);
      i16 = int'(inst_i[15:0]);
      hz  = m_busy(rd) || (!imm && m_busy(rs));
      rdy = !hz && !flush_i && (!m_sv || out_ready_i);
      acc = in_valid_i && rdy;
      wr  = m_wr(op);
      chk("in_ready", in_ready_o, rdy);
      chk("stall", stall_o, in_valid_i && hz);
      if (acc) begin
         if (m_cls(op) == 8'h20 || i16 < 32'h8000) ext = 32'(i16);
         else ext = 32'(i16) + 32'hFFFF_0000;
         pend.cls = m_cls(op);
         pend.rd  = 4'(rd);
         pend.wr  = wr;
         pend.o0  = (pend.cls == 8'h01) ? 32'h0 : m_read(rd);
         pend.o1  = (pend.cls == 8'h01) ? 32'h0 : (imm ? ext : m_read(rs));
         pend_v   = 1'b1;
      end
      if (wb_i) begin
         if (wb_r_i != 0) m_reg[wb_r_i] = wb_data_i;
         m_rsv[wb_r_i] = 1'b0;
      end
      if (flush_i && m_sv && m_swr) m_rsv[m_srd] = 1'b0;
      if (acc) begin
         m_sv  = 1'b1;
         m_swr = wr;
         m_srd = rd;
         if (wr && rd != 0) m_rsv[rd] = 1'b1;
      end else if (flush_i || out_ready_i) begin
         m_sv = 1'b0;
      end
   endtask

   task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy, input bit fl,
                        input bit w, input int wr, input logic [31:0] wd);
      @(posedge clk);
      if (pend_v) begin
         q.push_back(pend);
         pend_v = 1'b0;
      end
      #1;
      in_valid_i  = v;
      inst_i      = ins;
      out_ready_i = ordy;
      flush_i     = fl;
      wb_i        = w;
      wb_r_i      = 4'(wr);
      wb_data_i   = wd;
      #2;
      model_step();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", out_valid_o, 0);
      chk("rst_opr0", opr0_value_o, 0);
      chk("rst_opr1", opr1_value_o, 0);
      chk("rst_rd", rd_addr_o, 0);
      chk("rst_wr", wr_rd_o, 0);
      chk("rst_ctrl", {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_set_o,
                       ctrl_ld_o, ctrl_st_o, ctrl_br_o, ctrl_und_o}, 0);
   endtask

   // Monitor: the slot must match the queue head while it is presented.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", out_valid_o, q.size() != 0);
         if (out_valid_o && q.size() != 0) begin
            chk("opr0", opr0_value_o, q[0].o0);
            chk("opr1", opr1_value_o, q[0].o1);
            chk("rd_addr", rd_addr_o, q[0].rd);
            chk("wr_rd", wr_rd_o, q[0].wr);
            chk("ctrl", {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_set_o,
                         ctrl_ld_o, ctrl_st_o, ctrl_br_o, ctrl_und_o}, q[0].cls);
            if (out_ready_i || flush_i) void'(q.pop_front());
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      mon_en  = 1'b0;
      rst = 1'b0;
      in_valid_i = 1'b0; inst_i = '0; out_ready_i = 1'b0; flush_i = 1'b0;
      wb_i = 1'b0; wb_r_i = '0; wb_data_i = '0;
      model_clear();
      #12;
      chk_reset_outputs();
      in_valid_i = 1'b1;
      #1;
      chk("rst_in_ready", in_ready_o, 1);
      @(negedge clk);
      rst = 1'b1;
      in_valid_i = 1'b0;
      mon_en = 1'b1;

      // Issue with reservation, dependent stall, bypassed release.
      cycle(0, 0, 1, 0, 1, 4, 32'h5);
      cycle(1, mk(0, 0, 3, 4, 0), 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 1, 0, 32'hDEAD);
      chk("opr1_r4", opr1_value_o, 32'h5);
      chk("inte", ctrl_inte_o, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, mk(25, 1, 3, 0, 0), 1, 0, 0, 0, 0);
         chk("stall_r3", stall_o, 1);
      end
      cycle(1, mk(25, 1, 3, 0, 0), 1, 0, 1, 3, 32'h1234);
      chk("ready_wb_r3", in_ready_o, 1);
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("opr0_bypass", opr0_value_o, 32'h1234);

      // Immediate extension.
      cycle(1, mk(8, 1, 0, 0, 16'h8000), 1, 0, 0, 0, 0);
      cycle(1, mk(1, 1, 0, 0, 16'h8000), 1, 0, 0, 0, 0);
      chk("shift_zext", opr1_value_o, 32'h0000_8000);
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("inte_sext", opr1_value_o, 32'hFFFF_8000);

      // Backpressure then back-to-back transfers.
      cycle(1, mk(16, 1, 0, 0, 1), 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, mk(17, 1, 0, 0, 2 + i), 0, 0, 0, 0, 0);
         chk("bp_ready", in_ready_o, 0);
         chk("bp_hold", opr1_value_o, 32'h1);
      end
      for (int i = 0; i < 4; i++) cycle(1, mk(18, 1, 0, 0, 10 + i), 1, 0, 0, 0, 0);

      // Write-back and issue on the same register: reservation stays.
      cycle(1, mk(24, 1, 5, 0, 0), 1, 0, 1, 5, 32'h55);
      cycle(1, mk(25, 1, 5, 0, 0), 1, 0, 0, 0, 0);
      chk("r5_still_rsv", stall_o, 1);
      cycle(0, 0, 1, 0, 1, 5, 32'h66);

      // Flush of a ld releases its destination; und never reserves.
      cycle(1, mk(24, 1, 7, 0, 0), 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      chk("flush_pre", out_valid_o, 1);
      cycle(1, mk(25, 0, 7, 7, 0), 1, 0, 0, 0, 0);
      chk("flush_valid", out_valid_o, 0);
      chk("r7_released", in_ready_o, 1);
      cycle(1, mk(127, 0, 8, 9, 0), 1, 0, 0, 0, 0);
      cycle(1, mk(25, 0, 8, 8, 0), 1, 0, 0, 0, 0);
      chk("und_ctrl", ctrl_und_o, 1);
      chk("und_norsv", stall_o, 0);

      // r0 destination never reserves and always reads zero.
      cycle(1, mk(0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
      cycle(1, mk(25, 0, 0, 0, 0), 1, 0, 0, 0, 0);
      chk("r0_norsv", stall_o, 0);
      chk("r0_read", opr0_value_o, 0);

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         int wr;
         wr = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            int s;
            s = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) begin
               if (m_rsv[(s + k) % 16]) begin
                  wr = (s + k) % 16;
                  break;
               end
            end
         end
         cycle($urandom_range(0, 3) != 0,
               mk(ops[$urandom_range(0, 11)], $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 2) == 0, wr, $urandom);
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, 0);

      // Reset mid-operation discards slot and reservations.
      cycle(1, mk(24, 1, 6, 0, 0), 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst = 1'b0;
      in_valid_i = 1'b0;
      #1;
      chk_reset_outputs();
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      mon_en = 1'b1;
      cycle(1, mk(25, 0, 6, 6, 0), 1, 0, 0, 0, 0);
      chk("post_rst_norsv", stall_o, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("post_rst_r6", opr0_value_o, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode stage: decodes a 32-bit instruction into class controls, reads two operands from an internal general-purpose register file with a per-register reservation scoreboard, selects a sign- or zero-extended 16-bit immediate, and registers the result into a valid/ready pipeline slot. It sits between fetch and execute, adds write-back bypass, hazard stalls and flush, and is configurable in data width and register count.

## Interface
- XLEN, 32, operand/register data width (≥16)
- NREG, 16, number of registers (power of two, 2..16)
- RA_W, $clog2(NREG), register address width; fields still occupy 4 instruction bits, upper unused bits must be 0
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-low
- inst_i  in  32  instruction: opcode [31:25], imm-select [24], rd [23:20], rs [19:16], imm16 [15:0]
- in_valid_i  in  1  instruction valid from fetch
- in_ready_o  out  1  stage accepts instruction this cycle
- out_valid_o  out  1  decoded slot valid
- out_ready_i  in  1  execute accepts slot
- flush_i  in  1  kill slot contents
- wb_i  in  1  write-back enable
- wb_r_i  in  RA_W  write-back register
- wb_data_i  in  XLEN  write-back data
- opr0_value_o  out  XLEN  rd operand
- opr1_value_o  out  XLEN  rs operand or extended immediate
- rd_addr_o  out  RA_W  destination register
- wr_rd_o  out  1  instruction writes rd
- ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_set_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, ctrl_und_o  out  1 each  one-hot class
- stall_o  out  1  in_valid_i high but blocked by hazard

## Operation
- Classes: 0000xxx inte; 0001000–0001101 shift; 00100xx logic; 0010110/0010111 set; 0011000 ld; 0011001 st; 00111xx br; all else und.
- wr_rd: inte (except 0000100 compare), shift, logic, set, ld. st, br, und, compare: 0.
- Immediate (inst[24]=1): shift zero-extends imm16 to XLEN; all other classes sign-extend.
- r0 reads 0, ignores writes, never reserved.
- Operand read: if wb_i and wb_r_i matches read address (≠0), bypass wb_data_i; else register file.
- Hazard: rd reserved, or rs reserved with inst[24]=0; a reservation being cleared by wb_i this cycle does not count.
- Accept = in_valid_i & in_ready_o; in_ready_o = !hazard & !flush_i & (!out_valid_o | out_ready_i).
- On accept with wr_rd=1 and rd≠0: set reserve[rd]. Same-cycle wb clear and issue set of same register: set wins.
- wb_i: write register file, clear reserve[wb_r_i].
- und: issues with ctrl_und_o=1, operands 0, no reservation.
- flush_i: out_valid_o→0; if slot held wr_rd=1, clear reserve[rd_addr_o] (unless an accept sets it again — cannot occur, accept blocked).

## Timing
- Reset: all outputs 0, in_ready_o follows reset state (1 when in_valid_i and no hazard), register file 0, all reservations clear.
- Latency: accept at edge N → out_valid_o high after edge N, data stable until handshake.
- Slot held unchanged while out_valid_o & !out_ready_i.
- Write-back visible to register reads on same cycle via bypass, via array next cycle.
- in_ready_o and stall_o combinational from inputs and state; no other comb in→out paths.
- Reset mid-operation discards slot and all reservations.

## Structure
- Shared package id_pkg: opcode constants, class one-hot typedef, decode function, extend function.
- Sub-module gpr_scoreboard: register file, reserve bits, bypass, two read ports, one write port, set/clear ports.
- Top: decode, hazard, handshake, pipeline slot.

## Test plan
- Reset, issue 0000000 rd=3 rs=4 (r4=5): out opr1=5, ctrl_inte=1, reserve[3] set; next inst reading r3 stalls until wb r3=0x1234, then issues with opr0=0x1234 same cycle.
- Shift imm 0x8000 → opr1=0x0000_8000; inte imm 0x8000 → 0xFFFF_8000 (XLEN=32).
- out_ready_i low 3 cycles with in_valid_i high: in_ready_o=0, outputs frozen, then one transfer per cycle.
- wb r5 and issue writing r5 same cycle: reserve[5] remains set.
- Flush slot holding ld rd=7: out_valid_o=0 next cycle, reserve[7] cleared; opcode 1111111 → ctrl_und_o=1, no reservation.
- NREG=4, XLEN=16 build: rd=0 write never reserves, reads 0.
